// File: rtl/sqrt_pkg.sv
// Shared definitions for the iterative square-root block: FSM state codes and
// default radicand width.
package sqrt_pkg;

    localparam int DIN_W_DEF = 32;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        LOAD = 4'd1,
        CALC = 4'd2,
        DONE = 4'd3
    } state_t;

endpackage

// File: rtl/sqrt_step.sv
// One combinational digit-by-digit square-root iteration: brings down the next
// radicand bit pair, tries (root<<2)|1 against the remainder, emits one root bit.
module sqrt_step
    import sqrt_pkg::*;
#(
    parameter int DOUT_W = DIN_W_DEF / 2
) (
    input  logic [DOUT_W+1:0] rem_in,
    input  logic [DOUT_W-1:0] root_in,
    input  logic [1:0]        bits_in,
    output logic [DOUT_W+1:0] rem_out,
    output logic [DOUT_W-1:0] root_out
);

    logic [DOUT_W+1:0] rem_sh;
    logic [DOUT_W+1:0] trial;
    logic              take;

    // The incoming remainder never exceeds 2*root, so its top two bits are
    // always zero before the shift and can be dropped.
    logic unused_rem_hi;
    assign unused_rem_hi = ^rem_in[DOUT_W+1:DOUT_W];

    assign rem_sh   = {rem_in[DOUT_W-1:0], bits_in};
    assign trial    = {root_in, 2'b01};
    assign take     = (rem_sh >= trial);
    assign rem_out  = take ? (rem_sh - trial) : rem_sh;
    assign root_out = {root_in[DOUT_W-2:0], take};

endmodule

// File: rtl/sqrt.sv
// Sequential integer square root, one root bit per enabled cycle, MSB first.
// Define SQRT_ROUND_EN to round the result to nearest instead of flooring.
//
// state | meaning
// IDLE  | wait for enable
// LOAD  | capture din, clear remainder/root, arm down-counter
// CALC  | one root bit per enabled cycle until counter reaches 0
// DONE  | dout holds the new result, valid high for this cycle only
module sqrt
    import sqrt_pkg::*;
#(
    parameter int DIN_W = DIN_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIN_W-1:0]     din,
    output logic [DIN_W/2-1:0]   dout,
    output logic [3:0]           cstate,
    output logic                 valid
);

    localparam int DOUT_W = DIN_W / 2;
    localparam int CNT_W  = (DOUT_W > 1) ? $clog2(DOUT_W) : 1;

    if (DIN_W % 2 != 0) begin : g_din_w_odd
        $error("sqrt: DIN_W must be even");
    end

    state_t            state;
    state_t            state_nxt;
    logic [DIN_W-1:0]  operand;
    logic [DOUT_W+1:0] rem;
    logic [DOUT_W-1:0] root;
    logic [CNT_W-1:0]  cnt;
    logic [DOUT_W+1:0] rem_nxt;
    logic [DOUT_W-1:0] root_nxt;
    logic [DOUT_W-1:0] result;

    sqrt_step #(
        .DOUT_W (DOUT_W)
    ) u_step (
        .rem_in   (rem),
        .root_in  (root),
        .bits_in  (operand[DIN_W-1 -: 2]),
        .rem_out  (rem_nxt),
        .root_out (root_nxt)
    );

`ifdef SQRT_ROUND_EN
    // n - r*r > r means n is nearer (r+1)^2; an all-ones root cannot step up.
    assign result = ((rem_nxt > {2'b00, root_nxt}) && (root_nxt != '1))
                  ? root_nxt + {{(DOUT_W-1){1'b0}}, 1'b1}
                  : root_nxt;
`else
    assign result = root_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = LOAD;
            LOAD:    state_nxt = CALC;
            CALC:    if (enable && (cnt == '0)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            operand <= '0;
            rem     <= '0;
            root    <= '0;
            cnt     <= '0;
            dout    <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= (state_nxt == DONE);
            case (state)
                LOAD: begin
                    operand <= din;
                    rem     <= '0;
                    root    <= '0;
                    cnt     <= CNT_W'(DOUT_W - 1);
                end
                CALC: begin
                    if (enable) begin
                        operand <= {operand[DIN_W-3:0], 2'b00};
                        rem     <= rem_nxt;
                        root    <= root_nxt;
                        cnt     <= cnt - CNT_W'(1);
                        if (cnt == '0) begin
                            dout <= result;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cstate = state;

endmodule

// File: tb/tb_sqrt.sv
// Bench for sqrt: arithmetic reference model checked every cycle plus directed
// vectors with literal expectations (build with SQRT_ROUND_EN for rounding mode).
module tb_sqrt;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] din = '0;
    logic [15:0] dout;
    logic [3:0]  cstate;
    logic        valid;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    sqrt u_dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .din    (din),
        .dout   (dout),
        .cstate (cstate),
        .valid  (valid)
    );

    always #5 clk = ~clk;

`ifdef SQRT_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    function automatic longint ref_root(input longint n);
        longint lo = 0;
        longint hi = 65536;
        longint mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= n) lo = mid;
            else hi = mid;
        end
        if (ROUND && (n - lo * lo > lo) && (lo < 65535)) lo++;
        return lo;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 load, 2 calc, 3 done; result from ref_root.
    int          m_state = 0;
    int          m_iters = 0;
    longint      m_op = 0;
    logic [15:0] m_dout = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_state = 0;
            m_iters = 0;
            m_op    = 0;
            m_dout  = '0;
        end else begin
            case (m_state)
                0: if (enable) m_state = 1;
                1: begin
                    m_op    = longint'(din);
                    m_iters = 0;
                    m_state = 2;
                end
                2: if (enable) begin
                    m_iters++;
                    if (m_iters == 16) begin
                        m_state = 3;
                        m_dout  = 16'(ref_root(m_op));
                    end
                end
                default: m_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_cstate", 64'(cstate), 64'(m_state));
            chk("cyc_valid", 64'(valid), 64'(m_state == 3));
            chk("cyc_dout", 64'(dout), 64'(m_dout));
        end
    end

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!valid && n < 60);
        if (!valid) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: got no valid, expected valid within 60 cycles");
        end
    endtask

    task automatic run_one(input string name, input logic [31:0] d, input logic [15:0] exp);
        int n;
        @(negedge clk);
        din    = d;
        enable = 1'b1;
        wait_valid(n);
        chk({name, "_latency"}, 64'(n), 64'd18);
        chk(name, 64'(dout), 64'(exp));
        enable = 1'b0;
    endtask

    logic [31:0] v_din   [10] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'd99, 32'd90,
                                  32'd4, 32'd15, 32'd65536, 32'd2, 32'd3};
    logic [15:0] v_floor [10] = '{16'd0, 16'd1, 16'd65535, 16'd9, 16'd9,
                                  16'd2, 16'd3, 16'd256, 16'd1, 16'd1};
    logic [15:0] v_round [10] = '{16'd0, 16'd1, 16'd65535, 16'd10, 16'd9,
                                  16'd2, 16'd4, 16'd256, 16'd1, 16'd2};

    initial begin
        int  n;
        bit  seen;

        repeat (2) @(negedge clk);
        reset  = 1'b0;
        chk_on = 1;
        chk("reset_cstate", 64'(cstate), 64'd0);
        chk("reset_dout", 64'(dout), 64'd0);
        chk("reset_valid", 64'(valid), 64'd0);

        chk("model_99", 64'(ref_root(99)), ROUND ? 64'd10 : 64'd9);
        chk("model_max", 64'(ref_root(64'hFFFF_FFFF)), 64'd65535);

        // enable held high: 18-cycle first latency, then a 19-cycle period
        @(negedge clk);
        din    = 32'd10000;
        enable = 1'b1;
        wait_valid(n);
        chk("held_first_latency", 64'(n), 64'd18);
        chk("held_first_dout", 64'(dout), 64'd100);
        chk("held_first_cstate", 64'(cstate), 64'd3);
        wait_valid(n);
        chk("held_period", 64'(n), 64'd19);
        chk("held_second_dout", 64'(dout), 64'd100);
        enable = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_one($sformatf("vec_%0d", v_din[i]), v_din[i], ROUND ? v_round[i] : v_floor[i]);
        end

        // reset mid-CALC aborts the run and clears dout
        @(negedge clk);
        din    = 32'd10000;
        enable = 1'b1;
        repeat (6) @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        chk("abort_cstate", 64'(cstate), 64'd0);
        chk("abort_dout", 64'(dout), 64'd0);
        chk("abort_valid", 64'(valid), 64'd0);
        reset = 1'b0;
        seen  = 0;
        repeat (25) begin
            @(negedge clk);
            if (valid) seen = 1;
        end
        chk("abort_no_valid", 64'(seen), 64'd0);
        run_one("after_abort", 32'd10000, 16'd100);

        // enable dropped for 5 cycles mid-CALC
        @(negedge clk);
        din    = 32'd10000;
        enable = 1'b1;
        n      = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 6) enable = 1'b0;
            if (n == 9) chk("stall_cstate", 64'(cstate), 64'd2);
            if (n == 11) enable = 1'b1;
        end while (!valid && n < 60);
        chk("stall_latency", 64'(n), 64'd23);
        chk("stall_dout", 64'(dout), 64'd100);
        enable = 1'b0;

        // din change during CALC only affects the next run
        @(negedge clk);
        din    = 32'd10000;
        enable = 1'b1;
        repeat (5) @(negedge clk);
        din = 32'd4;
        wait_valid(n);
        chk("dinchg_latency", 64'(n), 64'd13);
        chk("dinchg_current", 64'(dout), 64'd100);
        wait_valid(n);
        chk("dinchg_next", 64'(dout), 64'd2);
        enable = 1'b0;

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sqrt.md
SQRT -- requirements
Module: sqrt

Interface
REQ-001 Parameter DIN_W, default 32, radicand width; SHALL be even.
REQ-002 Parameter DOUT_W, default DIN_W/2, root width; SHALL be derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  start/run qualifier.
REQ-006 din  input  DIN_W  unsigned radicand, sampled in LOAD only.
REQ-007 dout  output  DOUT_W  unsigned integer square root, registered.
REQ-008 cstate  output  4  current FSM state code, registered.
REQ-009 valid  output  1  result-ready strobe, registered.

Function
REQ-010 SHALL compute dout = floor(sqrt(din)) with a digit-by-digit (shift/subtract) method, one root bit per cycle, MSB first.
REQ-011 FSM codes SHALL be IDLE=0, LOAD=1, CALC=2, DONE=3; codes 4..15 unused and SHALL go to IDLE.
REQ-012 IDLE: go to LOAD when enable=1; otherwise stay.
REQ-013 LOAD: capture din into the internal operand, clear remainder/root, set iteration counter to DOUT_W-1; go to CALC.
REQ-014 CALC: one iteration per cycle while enable=1; enable=0 SHALL freeze all internal state; go to DONE after the iteration at counter=0 (exactly DOUT_W iterations).
REQ-015 Each iteration: rem = (rem<<2)|next two operand bits; trial = (root<<2)|1; if rem>=trial then rem-=trial, root=(root<<1)|1, else root<<=1; remainder width DOUT_W+2 bits.
REQ-016 DONE: dout loads the final root; valid=1 for exactly this one cycle; go to IDLE unconditionally.
REQ-017 Latency: IDLE samples enable=1 at edge k -> LOAD after k, CALC after k+1..k+16, DONE/valid=1 after k+17 (DIN_W=32).
REQ-018 With enable held high, computation SHALL repeat every 19 cycles, re-sampling din each LOAD.
REQ-019 dout SHALL hold its last value outside DONE entry; din changes outside LOAD SHALL NOT affect the result.
REQ-020 valid SHALL be high iff cstate=DONE.

Reset
REQ-021 reset=1 at a rising edge SHALL set cstate=IDLE, dout=0, valid=0 and clear operand, remainder, root, counter.
REQ-022 reset SHALL take priority over enable and any state, including mid-CALC; the aborted result SHALL never appear on dout.

Configuration
REQ-023 Macro SQRT_ROUND_EN: when defined, DONE SHALL load dout = root+1 if final remainder > root (round to nearest), saturating at 2^DOUT_W-1; when undefined, dout = root (floor).
REQ-024 Latency and FSM SHALL be identical with or without SQRT_ROUND_EN.

Structure
REQ-025 Package sqrt_pkg SHALL hold the state enum/codes and default width constants.
REQ-026 Sub-module sqrt_step SHALL implement one combinational iteration (rem, root, bit pair in -> rem, root out); sqrt SHALL hold FSM, counter and registers.

Verification
REQ-027 din=10000, enable held high after reset -> dout=100, valid=1, cstate=3 on cycle k+17; repeats every 19 cycles.
REQ-028 din=0 -> dout=0; din=1 -> dout=1; din=0xFFFFFFFF -> dout=65535 (both macro settings).
REQ-029 din=99 -> dout=9 without SQRT_ROUND_EN, 10 with it; din=90 -> 9 in both.
REQ-030 reset pulsed during CALC -> next cycle cstate=0, dout=0, valid=0; no valid until a fresh full run.
REQ-031 enable dropped for 5 cycles mid-CALC with din=10000 -> cstate stays 2, valid delayed by 5 cycles, dout=100.
REQ-032 din changed to 4 during CALC -> current result 100; next run yields 2.
